// File: rtl/aes_pkg.sv
// Purpose: shared constants, tables and GF(2^8) helpers for the iterative AES-128 engine.
// Contents: round count, datapath widths, FSM state type, forward S-box, round constants,
//           xtime / gmul2 / gmul3.
package aes_pkg;

  localparam int unsigned NR     = 10;
  localparam int unsigned BLK_W  = 128;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned RND_W  = 4;
  localparam int unsigned NBYTES = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_state_e;

  // Indexed directly by the round counter; entry 0 and entries above NR are unused.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] gmul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Purpose: combinational forward AES S-box, one byte in, one byte out.
// Ports: byte_i - input byte; sub_c_o - substituted byte (combinational).
module aes_sbox
  import aes_pkg::*;
(
  input  logic [BYTE_W-1:0] byte_i,
  output logic [BYTE_W-1:0] sub_c_o
);

  assign sub_c_o = SBOX[byte_i];

endmodule

// File: rtl/aes128_top.sv
// Purpose: iterative AES-128 encryption, one round per clock, round keys expanded on the fly.
// Ports: data/key  - plaintext and cipher key, captured when start is seen in IDLE
//        cipher    - registered ciphertext, valid while done=1
//        start     - request; a held-high start yields exactly one encryption
//        done      - registered, high while the result is held
//        clk, rst  - rising-edge clock, asynchronous active-low reset
module aes128_top
  import aes_pkg::*;
(
  input  logic [BLK_W-1:0] data,
  input  logic [BLK_W-1:0] key,
  output logic [BLK_W-1:0] cipher,
  input  logic             start,
  output logic             done,
  input  logic             clk,
  input  logic             rst
);

  aes_state_e        fsm_q, fsm_d;
  logic [BLK_W-1:0]  state_q, state_d;
  logic [BLK_W-1:0]  rk_q, rk_d;
  logic [BLK_W-1:0]  cipher_q, cipher_d;
  logic [RND_W-1:0]  round_q, round_d;
  logic              done_q, done_d;

  logic [BYTE_W-1:0] sb [NBYTES];
  logic [BYTE_W-1:0] sr [NBYTES];
  logic [BYTE_W-1:0] mc [NBYTES];
  logic [BLK_W-1:0]  rnd_out;
  logic [BLK_W-1:0]  rk_next;
  logic              last_round;

  assign last_round = (round_q == RND_W'(NR));

  // SubBytes: byte i of the state sits at bits [127-8i -: 8], i = row + 4*col.
  for (genvar i = 0; i < NBYTES; i++) begin : g_sub
    aes_sbox u_sbox (
      .byte_i  (state_q[BLK_W-1-BYTE_W*i -: BYTE_W]),
      .sub_c_o (sb[i])
    );
  end

  // ShiftRows: row r rotates left by r columns.
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign sr[r + 4*c] = sb[r + 4*((c + r) % 4)];
    end
  end

  // MixColumns: circulant {02 03 01 01} per column.
  for (genvar c = 0; c < 4; c++) begin : g_mix
    assign mc[4*c+0] = gmul2(sr[4*c+0]) ^ gmul3(sr[4*c+1]) ^ sr[4*c+2] ^ sr[4*c+3];
    assign mc[4*c+1] = sr[4*c+0] ^ gmul2(sr[4*c+1]) ^ gmul3(sr[4*c+2]) ^ sr[4*c+3];
    assign mc[4*c+2] = sr[4*c+0] ^ sr[4*c+1] ^ gmul2(sr[4*c+2]) ^ gmul3(sr[4*c+3]);
    assign mc[4*c+3] = gmul3(sr[4*c+0]) ^ sr[4*c+1] ^ sr[4*c+2] ^ gmul2(sr[4*c+3]);
  end

  // Key expansion for the current round, derived from the previous round key.
  logic [WORD_W-1:0] w0, w1, w2, w3, rot_w, sub_w, tmp_w;
  logic [WORD_W-1:0] n0, n1, n2, n3;

  assign w0    = rk_q[127:96];
  assign w1    = rk_q[95:64];
  assign w2    = rk_q[63:32];
  assign w3    = rk_q[31:0];
  assign rot_w = {w3[23:0], w3[31:24]};

  for (genvar j = 0; j < 4; j++) begin : g_subw
    aes_sbox u_sbox (
      .byte_i  (rot_w[WORD_W-1-BYTE_W*j -: BYTE_W]),
      .sub_c_o (sub_w[WORD_W-1-BYTE_W*j -: BYTE_W])
    );
  end

  assign tmp_w   = sub_w ^ {RCON[round_q], 24'h0};
  assign n0      = w0 ^ tmp_w;
  assign n1      = w1 ^ n0;
  assign n2      = w2 ^ n1;
  assign n3      = w3 ^ n2;
  assign rk_next = {n0, n1, n2, n3};

  // AddRoundKey; the final round bypasses MixColumns.
  for (genvar i = 0; i < NBYTES; i++) begin : g_ark
    assign rnd_out[BLK_W-1-BYTE_W*i -: BYTE_W] =
      (last_round ? sr[i] : mc[i]) ^ rk_next[BLK_W-1-BYTE_W*i -: BYTE_W];
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q    <= IDLE;
      state_q  <= '0;
      rk_q     <= '0;
      cipher_q <= '0;
      round_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      state_q  <= state_d;
      rk_q     <= rk_d;
      cipher_q <= cipher_d;
      round_q  <= round_d;
      done_q   <= done_d;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    fsm_d    = fsm_q;
    state_d  = state_q;
    rk_d     = rk_q;
    cipher_d = cipher_q;
    round_d  = round_q;
    done_d   = done_q;
    case (fsm_q)
      IDLE: begin
        if (start) begin
          state_d = data ^ key;
          rk_d    = key;
          round_d = RND_W'(1);
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        state_d = rnd_out;
        rk_d    = rk_next;
        round_d = round_q + RND_W'(1);
        if (last_round) begin
          cipher_d = rnd_out;
          done_d   = 1'b1;
          fsm_d    = DONE;
        end
      end
      DONE: begin
        // Exit only once start drops, so a held start cannot retrigger.
        if (!start) begin
          done_d = 1'b0;
          fsm_d  = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  assign cipher = cipher_q;
  assign done   = done_q;

endmodule

// File: tb/tb_aes128_top.sv
// Purpose: scoreboard bench for aes128_top with a textbook AES-128 reference model.
module tb_aes128_top;

  logic [127:0] data, key, cipher;
  logic         start, done, clk, rst;

  int n_cmp = 0;
  int n_err = 0;

  logic [127:0] exp_q [$];
  logic [7:0]   m_sbox [256];

  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  aes128_top dut (
    .data   (data),
    .key    (key),
    .cipher (cipher),
    .start  (start),
    .done   (done),
    .clk    (clk),
    .rst    (rst)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  // S-box from first principles: multiplicative inverse then affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] b, inv;
      b = 8'(x);
      inv = 8'h01;
      for (int e = 0; e < 254; e++) inv = gf_mul(inv, b);
      m_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_model(input logic [127:0] pt, input logic [127:0] k);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a [4];
    logic [7:0]   rc;
    logic [31:0]  tmp;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {m_sbox[tmp[31:24]], m_sbox[tmp[23:16]], m_sbox[tmp[15:8]], m_sbox[tmp[7:0]]};
        tmp[31:24] = tmp[31:24] ^ rc;
        rc = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ w[c][31-8*r -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = m_sbox[s[i]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) s[r+4*c] = t[r+4*((c+r)%4)];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) a[r] = s[4*c+r];
          for (int r = 0; r < 4; r++)
            s[4*c+r] = gf_mul(8'h02, a[r]) ^ gf_mul(8'h03, a[(r+1)%4]) ^ a[(r+2)%4] ^ a[(r+3)%4];
        end
      end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ w[4*rnd+c][31-8*r -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- monitor ----------------
  initial begin
    logic done_prev;
    done_prev = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (done && !done_prev) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: got cipher %h with nothing expected", cipher);
        end else begin
          check("cipher", cipher, exp_q.pop_front());
        end
      end
      done_prev = done;
    end
  end

  // ---------------- driver ----------------
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: got done=0 after %0d cycles want done=1", n);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
  endtask

  task automatic run_op(input logic [127:0] d, input logic [127:0] k,
                        input logic [127:0] exp, input bit chk_r1);
    int n;
    @(negedge clk);
    data = d; key = k; start = 1'b1;
    exp_q.push_back(exp);
    if (chk_r1) begin
      @(posedge clk);
      @(posedge clk); #1;
      check("round1_state", dut.state_q, 128'ha49c7ff2689f352b6b5bea43026a5049);
      check("round1_rk", dut.rk_q, 128'ha0fafe1788542cb123a339392a6c7605);
    end
    wait_done(n);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check("done_fall", 128'(done), 128'd0);
  endtask

  initial begin
    int           n, hold_ok;
    logic [127:0] d, k, c_exp;

    build_sbox();
    rst = 1'b1; start = 1'b0; data = '0; key = '0;
    #2 rst = 1'b0;

    // Reset held two cycles with start already high.
    data = 128'h046681e5e0cb199a48f8d37a2806264c;
    key  = 128'ha0fafe1788542cb123a339392a6c7605;
    start = 1'b1;
    c_exp = aes_model(data, key);
    exp_q.push_back(c_exp);
    @(posedge clk); #1;
    check("rst_cipher", cipher, 128'd0);
    check("rst_done", 128'(done), 128'd0);
    check("rst_state", dut.state_q, 128'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    wait_done(n);
    check("latency", 128'(n), 128'd11);

    // Held start: no second run, result stays put.
    hold_ok = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done && cipher === c_exp) hold_ok++;
    end
    check("hold_cycles", 128'(hold_ok), 128'd15);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check("done_drop", 128'(done), 128'd0);
    check("cipher_kept", cipher, c_exp);

    // Known-answer vectors.
    run_op(B_PT, B_KEY, B_CT, 1'b1);
    run_op(C_PT, C_KEY, C_CT, 1'b0);

    // Inputs change while rounds are in flight.
    d = rand128(); k = rand128();
    @(negedge clk);
    data = d; key = k; start = 1'b1;
    exp_q.push_back(aes_model(d, k));
    repeat (3) @(posedge clk);
    @(negedge clk);
    data = rand128(); key = rand128();
    wait_done(n);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check("done_fall_chg", 128'(done), 128'd0);
    run_op(C_PT, C_KEY, C_CT, 1'b0);

    // Asynchronous reset in the middle of round 5.
    @(negedge clk);
    data = rand128(); key = rand128(); start = 1'b1;
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("midrst_cipher", cipher, 128'd0);
    check("midrst_done", 128'(done), 128'd0);
    check("midrst_round", 128'(dut.round_q), 128'd0);
    @(negedge clk);
    rst = 1'b1; start = 1'b0;

    // Full run afterwards, then reset while the result is held.
    d = rand128(); k = rand128();
    @(negedge clk);
    data = d; key = k; start = 1'b1;
    exp_q.push_back(aes_model(d, k));
    wait_done(n);
    #2 rst = 1'b0;
    #1;
    check("donerst_done", 128'(done), 128'd0);
    check("donerst_cipher", cipher, 128'd0);
    @(negedge clk);
    rst = 1'b1; start = 1'b0;

    // Random traffic.
    for (int i = 0; i < 8; i++) begin
      d = rand128(); k = rand128();
      run_op(d, k, aes_model(d, k), 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 128'(exp_q.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
